axis_i2c_cmd_queue: RTL and testbench

//  Command buffer directly upstream of axis_i2c_slave. Accepts I2C commands on an AXI-Stream slave,

---
 rtl/axis_i2c_pkg.sv | 15 +
 rtl/axis_i2c_sync_fifo.sv | 62 ++++++
 rtl/axis_i2c_cmd_queue.sv | 93 +++++++++
 tb/tb_axis_i2c_cmd_queue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_i2c_pkg.sv
// rtl/axis_i2c_pkg.sv - shared widths and command-queue state encoding for the I2C AXIS blocks
package axis_i2c_pkg;

  localparam int AXIS_DATA_WIDTH = 16;
  localparam int I2C_DATA_WIDTH  = 8;
  localparam int I2C_RW_BIT      = 0;

  typedef enum logic [1:0] {
    CQ_IDLE,
    CQ_SEND,
    CQ_BUSY,
    CQ_GAP
  } cmd_q_state_t;

endpackage

// File: rtl/axis_i2c_sync_fifo.sv
// rtl/axis_i2c_sync_fifo.sv - single-clock FIFO with registered full/empty flags and fill level
module axis_i2c_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + (AW+1)'(1);
      2'b01:   count_d = count - (AW+1)'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Flags are registered from the next count so downstream tready is glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == (AW+1)'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/axis_i2c_cmd_queue.sv
// rtl/axis_i2c_cmd_queue.sv - command FIFO feeding axis_i2c_slave, holding tdata per transaction
module axis_i2c_cmd_queue
  import axis_i2c_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int BUS_FREE_CYCLES = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]    level_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int GAP_W = (BUS_FREE_CYCLES > 0) ? $clog2(BUS_FREE_CYCLES + 1) : 1;

  cmd_q_state_t               state_q, state_d;
  logic [AXIS_DATA_WIDTH-1:0] hold_q;
  logic [AXIS_DATA_WIDTH-1:0] fifo_rdata;
  logic [GAP_W-1:0]           gap_q;
  logic                       seen_low_q;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic                       done_d;

  assign s_axis_tready = ~fifo_full & ~rst_i;
  assign m_axis_tdata  = hold_q;

  axis_i2c_sync_fifo #(
    .WIDTH (AXIS_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (s_axis_tvalid & s_axis_tready),
    .wdata (s_axis_tdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      CQ_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = CQ_SEND;
      end
      CQ_SEND: if (m_axis_tready) state_d = CQ_BUSY;
      // Only a low-then-high ready sequence marks completion; the handshake-cycle high is stale.
      CQ_BUSY: if (seen_low_q && m_axis_tready) begin
        done_d  = 1'b1;
        state_d = CQ_GAP;
      end
      CQ_GAP:  if (gap_q == '0) state_d = CQ_IDLE;
      default: state_d = CQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= CQ_IDLE;
      hold_q        <= '0;
      gap_q         <= '0;
      seen_low_q    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_axis_tvalid <= (state_d == CQ_SEND);
      busy_o        <= (state_d != CQ_IDLE);
      done_o        <= done_d;
      if (fifo_pop) hold_q <= fifo_rdata;
      if (state_q == CQ_SEND)                        seen_low_q <= 1'b0;
      else if (state_q == CQ_BUSY && !m_axis_tready) seen_low_q <= 1'b1;
      if (done_d)                              gap_q <= GAP_W'(BUS_FREE_CYCLES);
      else if (state_q == CQ_GAP && gap_q != '0) gap_q <= gap_q - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_i2c_cmd_queue.sv
// tb/tb_axis_i2c_cmd_queue.sv - self-checking bench for axis_i2c_cmd_queue
module tb_axis_i2c_cmd_queue;

  localparam int DEPTH = 16;
  localparam int B     = 4;

  localparam int K_TVALID = 0, K_TDATA = 1, K_LEVEL = 2, K_BUSY = 3,
                 K_DONE = 4, K_TREADY = 5, K_TIMEOUT = 6, K_LEFT = 7;

  typedef struct {int c; int kind; int val; int act;} lit_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [4:0]  level;
  logic        busy;
  logic        done;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  lit_t lits[$];
  int   ds_mode = 0;
  int   ds_low = 20;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_i2c_cmd_queue #(.FIFO_DEPTH(DEPTH), .BUS_FREE_CYCLES(B)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .level_o       (level),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input int kind, input int val);
    lits.push_back('{c, kind, val, 0});
  endtask

  task automatic note_timeout();
    lits.push_back('{cyc + 1, K_TIMEOUT, 0, 1});
  endtask

  // Downstream slave: mode 0 drops ready for ds_low cycles after each accept, 1 stalls, 2 stays ready.
  initial begin
    int  cnt;
    bit  hs;
    cnt = 0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = m_tvalid && m_tready;
      @(posedge clk);
      #1;
      case (ds_mode)
        0: if (hs) begin
             m_tready = 1'b0;
             cnt = ds_low;
           end else if (cnt > 0) begin
             cnt--;
             if (cnt == 0) m_tready = 1'b1;
           end else m_tready = 1'b1;
        1: m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Transaction-level model: queue of commands, expected level and downstream phase.
  initial begin
    logic [15:0] q[$];
    logic [15:0] cur;
    int  lvl, phase, gap_left;
    bit  vld, busy_e, done_e, gap_on;
    bit  push, hs, npop, ndone, nbusy, nvld;
    int  act;
    string nm;
    lvl = 0; phase = 0; gap_left = 0; vld = 0; busy_e = 0; done_e = 0; gap_on = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        chk("tready_in_reset", int'(s_tready), 0);
        q.delete();
        lvl = 0; phase = 0; gap_left = 0; vld = 0; busy_e = 0; done_e = 0; gap_on = 0; cur = '0;
      end else begin
        chk("level", int'(level), lvl);
        chk("s_tready", int'(s_tready), int'(lvl < DEPTH));
        chk("tvalid", int'(m_tvalid), int'(vld));
        chk("busy", int'(busy), int'(busy_e));
        chk("done", int'(done), int'(done_e));
        if (vld || busy_e) chk("tdata", int'(m_tdata), int'(cur));

        push  = s_tvalid && (lvl < DEPTH);
        hs    = vld && m_tready;
        npop  = !busy_e && (lvl > 0);
        ndone = (phase == 2) && m_tready;
        if (push) q.push_back(s_tdata);
        if (npop) cur = q.pop_front();
        nvld = npop || (vld && !hs);
        if (hs) phase = 1;
        else if (phase == 1 && !m_tready) phase = 2;
        else if (ndone) phase = 0;
        if (npop) nbusy = 1;
        else if (gap_on) begin
          if (gap_left == 0) begin
            nbusy = 0;
            gap_on = 0;
          end else begin
            gap_left--;
            nbusy = 1;
          end
        end else nbusy = busy_e;
        if (ndone) begin
          gap_on = 1;
          gap_left = B;
        end
        lvl    = lvl + int'(push) - int'(npop);
        vld    = nvld;
        busy_e = nbusy;
        done_e = ndone;
      end
      for (int i = 0; i < lits.size(); ) begin
        if (lits[i].c == cyc) begin
          case (lits[i].kind)
            K_TVALID:  begin act = int'(m_tvalid); nm = "lit_tvalid"; end
            K_TDATA:   begin act = int'(m_tdata);  nm = "lit_tdata"; end
            K_LEVEL:   begin act = int'(level);    nm = "lit_level"; end
            K_BUSY:    begin act = int'(busy);     nm = "lit_busy"; end
            K_DONE:    begin act = int'(done);     nm = "lit_done"; end
            K_TREADY:  begin act = int'(s_tready); nm = "lit_s_tready"; end
            K_TIMEOUT: begin act = lits[i].act;    nm = "wait_timeout"; end
            default:   begin act = lits[i].act;    nm = "unchecked_literals"; end
          endcase
          chk(nm, act, lits[i].val);
          lits.delete(i);
        end else i++;
      end
    end
  end

  task automatic push_cmd(input logic [15:0] d, output int acc);
    bit ok;
    ok = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1;
        break;
      end
    end
    acc = cyc;
    if (!ok) note_timeout();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && level == 0 && !m_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) note_timeout();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, c, d;
    bit ok;
    rst_i = 1'b1; s_tvalid = 1'b0; s_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    c = cyc;
    expect_at(c, K_LEVEL, 0); expect_at(c, K_TVALID, 0); expect_at(c, K_BUSY, 0);
    expect_at(c, K_DONE, 0);  expect_at(c, K_TDATA, 0);  expect_at(c, K_TREADY, 1);
    repeat (2) @(posedge clk);
    #1;

    // single write command, downstream busy for 20 cycles
    push_cmd(16'h5AA0, n);
    expect_at(n + 1, K_TVALID, 0); expect_at(n + 1, K_LEVEL, 1);
    expect_at(n + 2, K_TVALID, 1); expect_at(n + 2, K_TDATA, 16'h5AA0); expect_at(n + 2, K_LEVEL, 0);
    expect_at(n + 15, K_TDATA, 16'h5AA0);
    expect_at(n + 23, K_DONE, 0); expect_at(n + 24, K_DONE, 1); expect_at(n + 25, K_DONE, 0);
    expect_at(n + 28, K_BUSY, 1); expect_at(n + 29, K_BUSY, 0);
    wait_idle(200);

    // three back-to-back commands
    ds_low = 3;
    push_cmd(16'h1102, n);
    expect_at(n + 2, K_TDATA, 16'h1102);
    push_cmd(16'h2204, n);
    push_cmd(16'h3307, n);
    wait_idle(300);

    // fill with downstream stalled: one held + DEPTH queued, next push blocked
    ds_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i <= DEPTH; i++) push_cmd(16'h4000 + 16'(i), n);
    c = cyc;
    expect_at(c, K_LEVEL, DEPTH); expect_at(c, K_TREADY, 0);
    s_tvalid = 1'b1;
    s_tdata  = 16'h4011;
    repeat (3) @(negedge clk);
    ds_low  = 2;
    ds_mode = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) note_timeout();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    wait_idle(1000);

    // push coinciding with pop at level 5
    ds_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) push_cmd(16'h6000 + 16'(i), n);
    repeat (2) @(posedge clk);
    #1;
    ds_mode = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) note_timeout();
    d = cyc;
    expect_at(d + B + 1, K_LEVEL, 5); expect_at(d + B + 2, K_LEVEL, 5);
    expect_at(d + B + 2, K_TVALID, 1); expect_at(d + B + 2, K_TDATA, 16'h6001);
    for (int i = 0; i < 20 && cyc < d + B + 1; i++) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = 16'h60A5;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    wait_idle(400);

    // downstream ready never drops: stuck in BUSY, then reset with 4 queued
    ds_mode = 2;
    @(posedge clk);
    #1;
    push_cmd(16'h7781, n);
    for (int i = 1; i <= 4; i++) push_cmd(16'h8000 + 16'(i), c);
    expect_at(n + 20, K_DONE, 0); expect_at(n + 20, K_BUSY, 1);
    expect_at(n + 20, K_TDATA, 16'h7781); expect_at(n + 20, K_LEVEL, 4);
    while (cyc < n + 22) begin
      @(posedge clk);
      #1;
    end
    c = cyc;
    expect_at(c, K_TREADY, 0);
    expect_at(c + 1, K_LEVEL, 0); expect_at(c + 1, K_TVALID, 0); expect_at(c + 1, K_TDATA, 0);
    expect_at(c + 1, K_BUSY, 0);  expect_at(c + 1, K_TREADY, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ds_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    push_cmd(16'h9AB1, n);
    expect_at(n + 2, K_TDATA, 16'h9AB1);
    wait_idle(200);

    lits.push_back('{cyc + 1, K_LEFT, 0, lits.size()});
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
